// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
// The active configuration is carried at a fixed maximum width.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int LW          = $clog2(DEF_MAX_LEN + 1);
  localparam logic [DEF_MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1101;
  localparam int DEF_LEN     = 4;

  // Widest pattern the stored configuration can hold; MAX_LEN must not exceed it.
  localparam int CFG_PAT_W = 32;
  localparam int CFG_LEN_W = $clog2(CFG_PAT_W + 1);

  typedef struct packed {
    logic [CFG_PAT_W-1:0] pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
  } seq_cfg_t;

  function automatic logic len_valid(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector: Mealy match output, registered
// copy, overlap/non-overlap modes and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN         = DEF_MAX_LEN,
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int                 DEFAULT_LEN     = DEF_LEN,
  localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               y,
  output logic               y_reg,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  seq_cfg_t             cfg;
  // The oldest of MAX_LEN past bits can never reach a window of at most MAX_LEN bits.
  logic [MAX_LEN-2:0]   hist;
  logic [LEN_W-1:0]     fill;

  logic [MAX_LEN-1:0]   w_raw;
  logic [CFG_PAT_W-1:0] window;
  logic [CFG_PAT_W-1:0] len_mask;
  logic                 fill_ok;
  logic                 pat_ok;
  logic                 cfg_ok;
  logic                 accept;
  logic                 match;

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves len_mask unassigned and infers a latch.
    len_mask = '0;
    for (int i = 0; i < CFG_PAT_W; i++) begin
      len_mask[i] = (CFG_LEN_W'(i) < cfg.len);
    end
  end

  assign w_raw   = {hist, din};
  assign window  = CFG_PAT_W'(w_raw);
  assign pat_ok  = ((window ^ cfg.pattern) & len_mask) == '0;
  assign fill_ok = (CFG_LEN_W'(fill) + CFG_LEN_W'(1)) >= cfg.len;
  assign cfg_ok  = len_valid(int'(cfg_len), MAX_LEN);
  assign accept  = din_valid && !cfg_we;
  assign match   = accept && fill_ok && pat_ok;
  assign y       = match;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      fill    <= '0;
      cfg     <= '{pattern: CFG_PAT_W'(DEFAULT_PATTERN),
                   len:     CFG_LEN_W'(DEFAULT_LEN),
                   overlap: 1'b1};
      y_reg   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      y_reg   <= match;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we) begin
        // A rejected write leaves both configuration and history untouched.
        if (cfg_ok) begin
          cfg  <= '{pattern: CFG_PAT_W'(cfg_pattern),
                    len:     CFG_LEN_W'(cfg_len),
                    overlap: cfg_overlap};
          hist <= '0;
          fill <= '0;
        end
      end else if (din_valid) begin
        hist <= w_raw[MAX_LEN-2:0];
        if (match && !cfg.overlap) begin
          fill <= '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (count_clr),
    .en    (match),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: table-driven streams plus hand-written
// corner sequences; a CNT_W=2 instance shares the stimulus for saturation.
module tb_seq_detect_param;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic       din;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       count_clr;
  logic       y;
  logic       y_reg;
  logic [7:0] match_count;
  logic       cfg_err;
  logic       y2;
  logic       y_reg2;
  logic [1:0] count2;
  logic       cfg_err2;

  int checks   = 0;
  int failures = 0;
  logic y_s;
  logic y2_s;

  seq_detect_param u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .y           (y),
    .y_reg       (y_reg),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .y           (y2),
    .y_reg       (y_reg2),
    .match_count (count2),
    .cfg_err     (cfg_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       d;
    logic       ey;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; y is sampled before the rising edge,
  // registered outputs 1 time unit after it.
  task automatic drive(input logic v, input logic d, input logic we, input logic clr);
    @(negedge clk);
    din_valid = v;
    din       = d;
    cfg_we    = we;
    count_clr = clr;
    #1;
    y_s  = y;
    y2_s = y2;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("cfg_ok no err", cfg_err, 1'b0);
  endtask

  task automatic clear_count();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("count cleared", match_count, 8'd0);
  endtask

  // Stream bits are sent MSB first; ymask marks the hand-computed match bits.
  task automatic build(input logic [31:0] stream, input logic [31:0] ymask,
                       input int n, input int gap);
    logic [7:0] cnt;
    cnt = 8'd0;
    vecs.delete();
    for (int i = n - 1; i >= 0; i--) begin
      if (ymask[i]) cnt = cnt + 8'd1;
      vecs.push_back('{v: 1'b1, d: stream[i], ey: ymask[i], ecnt: cnt});
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          vecs.push_back('{v: 1'b0, d: ~stream[i], ey: 1'b0, ecnt: cnt});
        end
      end
    end
  endtask

  task automatic run(input string tag);
    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].d, 1'b0, 1'b0);
      check($sformatf("%s y[%0d]", tag, k), y_s, vecs[k].ey);
      check($sformatf("%s y_reg[%0d]", tag, k), y_reg, vecs[k].ey);
      check($sformatf("%s count[%0d]", tag, k), match_count, vecs[k].ecnt);
    end
  endtask

  task automatic feed_1101(input string tag);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check({tag, " b1"}, y_s, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check({tag, " b2"}, y_s, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check({tag, " b3"}, y_s, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check({tag, " b4"}, y_s, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    din_valid   = 1'b0;
    din         = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = 8'd0;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    count_clr   = 1'b0;
    y_s         = 1'b0;
    y2_s        = 1'b0;

    #12;
    check("reset y", y, 1'b0);
    check("reset y_reg", y_reg, 1'b0);
    check("reset count", match_count, 8'd0);
    check("reset cfg_err", cfg_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults, overlap: 11011011101 matches on bits 4, 7, 11.
    build(32'b11011011101, 32'b00010010001, 11, 0);
    run("ovl");

    // Non-overlap: bit 7 is suppressed.
    load_cfg(8'b0000_1101, 4'd4, 1'b0);
    clear_count();
    build(32'b11011011101, 32'b00010000001, 11, 0);
    run("novl");

    // Length-8 pattern, contiguous then with 3-cycle gaps.
    load_cfg(8'b1010_1010, 4'd8, 1'b1);
    clear_count();
    build(32'b1010101010, 32'b0000000101, 10, 0);
    run("len8");
    load_cfg(8'b1010_1010, 4'd8, 1'b1);
    clear_count();
    build(32'b1010101010, 32'b0000000101, 10, 3);
    run("len8gap");

    // Saturation on the 2-bit counter; clear beats a simultaneous match.
    load_cfg(8'b0000_1101, 4'd4, 1'b1);
    clear_count();
    for (int k = 1; k <= 5; k++) begin
      feed_1101($sformatf("sat%0d", k));
      check($sformatf("sat%0d count", k), match_count, 8'(k));
      check($sformatf("sat%0d count2", k), count2, (k > 3) ? 2'd3 : 2'(k));
      check($sformatf("sat%0d y_reg2", k), y_reg2, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr match y", y_s, 1'b1);
    check("clr match y2", y2_s, 1'b1);
    check("clr count", match_count, 8'd0);
    check("clr count2", count2, 2'd0);

    // Rejected config writes: len 0 and len 9.
    cfg_pattern = 8'hFF;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("len0 cfg_err", cfg_err, 1'b1);
    check("len0 cfg_err2", cfg_err2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("len0 err pulse", cfg_err, 1'b0);
    cfg_len = 4'd9;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("len9 y during we", y_s, 1'b0);
    check("len9 cfg_err", cfg_err, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("len9 err pulse", cfg_err, 1'b0);
    feed_1101("kept");
    check("kept count", match_count, 8'd1);

    // Valid write on the final bit of 1101: no match, history cleared.
    cfg_pattern = 8'b0000_1101;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("we last bit y", y_s, 1'b0);
    check("we last bit count", match_count, 8'd1);
    check("we last bit cfg_err", cfg_err, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("hist cleared y", y_s, 1'b0);
    check("hist cleared count", match_count, 8'd1);

    // Asynchronous reset mid-stream after 110.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async count", match_count, 8'd0);
    check("async y_reg", y_reg, 1'b0);
    check("async cfg_err", cfg_err, 1'b0);
    check("async y", y, 1'b0);
    din_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("post rst y", y_s, 1'b0);
    check("post rst y_reg", y_reg, 1'b0);
    check("post rst count", match_count, 8'd0);
    feed_1101("post rst");
    check("post rst y_reg hit", y_reg, 1'b1);
    check("post rst count hit", match_count, 8'd1);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
